// File: rtl/mem_port_arbiter.sv
// Two-port SRAM arbiter: instruction fetch and data ports share one SRAM through an
// IDLE/ACCESS/DONE sequencer with data-first priority and a fetch anti-starvation counter.
module mem_port_arbiter #(
    parameter int WORD_WIDTH   = 32,
    parameter int WAIT_CYCLES  = 3,
    parameter int STARVE_LIMIT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [WORD_WIDTH-1:0] if_addr,
    output logic [WORD_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [WORD_WIDTH-1:0] mem_addr,
    input  logic [WORD_WIDTH-1:0] mem_wdata,
    output logic [WORD_WIDTH-1:0] mem_rdata,
    output logic                  mem_ready,
    output logic                  if_stall,
    output logic                  mem_stall,
    output logic [WORD_WIDTH-1:0] sram_addr,
    output logic [WORD_WIDTH-1:0] sram_wdata,
    output logic                  sram_re,
    output logic                  sram_we,
    input  logic [WORD_WIDTH-1:0] sram_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] WAIT_INIT  = 4'(WAIT_CYCLES - 1);
    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    state_t                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [2:0]            starve_cnt_q, starve_cnt_d;
    logic                  grant_if_q, grant_if_d;
    logic                  write_q, write_d;
    logic [WORD_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic [WORD_WIDTH-1:0] sram_wdata_q, sram_wdata_d;
    logic [WORD_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [WORD_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
    logic                  mem_req;
    logic                  pick_if;

    assign mem_req = mem_rd | mem_wr;
    // Fetch only wins over a pending data request once the data port has had its quota.
    assign pick_if = if_req & (~mem_req | (starve_cnt_q == STARVE_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            starve_cnt_q <= '0;
            grant_if_q   <= 1'b0;
            write_q      <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            grant_if_q   <= grant_if_d;
            write_q      <= write_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        starve_cnt_d = starve_cnt_q;
        grant_if_d   = grant_if_q;
        write_d      = write_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        case (state_q)
            IDLE: begin
                if (if_req | mem_req) begin
                    state_d    = ACCESS;
                    wait_cnt_d = WAIT_INIT;
                    grant_if_d = pick_if;
                    if (pick_if) begin
                        sram_addr_d  = if_addr;
                        write_d      = 1'b0;
                        starve_cnt_d = '0;
                    end else begin
                        sram_addr_d  = mem_addr;
                        sram_wdata_d = mem_wdata;
                        write_d      = mem_wr;
                        if (if_req && (starve_cnt_q != STARVE_MAX)) begin
                            starve_cnt_d = starve_cnt_q + 3'd1;
                        end
                    end
                end
            end
            ACCESS: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!write_q) begin
                        if (grant_if_q) begin
                            if_rdata_d = sram_rdata;
                        end else begin
                            mem_rdata_d = sram_rdata;
                        end
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        sram_re   = (state_q == ACCESS) & ~write_q;
        sram_we   = (state_q == ACCESS) & write_q;
        if_ready  = (state_q == DONE) & grant_if_q;
        mem_ready = (state_q == DONE) & ~grant_if_q;
    end

    assign if_stall   = if_req & ~if_ready;
    assign mem_stall  = mem_req & ~mem_ready;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single transfers plus hand-written multi-cycle
// sequences; completions are matched against a queue of expected ready pulses.
module tb_mem_port_arbiter;
    localparam int WW   = 32;
    localparam int WAIT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [WW-1:0] if_addr;
    logic [WW-1:0] if_rdata;
    logic          if_ready;
    logic          mem_rd;
    logic          mem_wr;
    logic [WW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;
    logic [WW-1:0] mem_rdata;
    logic          mem_ready;
    logic          if_stall;
    logic          mem_stall;
    logic [WW-1:0] sram_addr;
    logic [WW-1:0] sram_wdata;
    logic          sram_re;
    logic          sram_we;
    logic [WW-1:0] sram_rdata;

    typedef struct {
        logic          fetch;
        logic          rd;
        logic          wr;
        logic [WW-1:0] addr;
        logic [WW-1:0] wdata;
        logic [WW-1:0] rdata;
        logic          exp_we;
        logic [WW-1:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic          is_if;
        logic [WW-1:0] rdata;
        int            cycle;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    mem_port_arbiter #(.WORD_WIDTH(WW), .WAIT_CYCLES(WAIT), .STARVE_LIMIT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .if_stall  (if_stall),
        .mem_stall (mem_stall),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .sram_re   (sram_re),
        .sram_we   (sram_we),
        .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b, want %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and retire any completion the DUT reports there.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rst) begin
            while (sb.size() > 0 && sb[0].cycle < cyc) begin
                e = sb.pop_front();
                checkOutput("missed_ready_cycle", 32'(cyc), 32'(e.cycle));
            end
            if (if_ready || mem_ready) begin
                checkBit("single_ready", if_ready & mem_ready, 1'b0);
                if (sb.size() == 0) begin
                    checkBit("unexpected_ready", if_ready | mem_ready, 1'b0);
                end else begin
                    e = sb.pop_front();
                    checkBit("ready_port", if_ready, e.is_if);
                    checkOutput("ready_cycle", 32'(cyc), 32'(e.cycle));
                    checkOutput("ready_rdata", e.is_if ? if_rdata : mem_rdata, e.rdata);
                end
            end
        end
    endtask

    task automatic expect_ready(input logic is_if, input logic [WW-1:0] rdata, input int cycle);
        exp_t e;
        e.is_if = is_if;
        e.rdata = rdata;
        e.cycle = cycle;
        sb.push_back(e);
    endtask

    // One isolated transfer started from IDLE; returns at the falling edge of the next IDLE cycle.
    task automatic applyStimulus(input vec_t v);
        if_req     = v.fetch;
        mem_rd     = v.rd;
        mem_wr     = v.wr;
        if_addr    = v.fetch ? v.addr : 32'hBAD0_0000;
        mem_addr   = v.fetch ? 32'hBAD1_0000 : v.addr;
        mem_wdata  = v.wdata;
        sram_rdata = v.rdata;
        expect_ready(v.fetch, v.exp_rdata, cyc + WAIT + 1);
        #1;
        checkBit("stall_cycle0", v.fetch ? if_stall : mem_stall, 1'b1);
        for (int i = 1; i <= WAIT; i++) begin
            tick();
            checkBit("sram_re", sram_re, ~v.exp_we);
            checkBit("sram_we", sram_we, v.exp_we);
            checkOutput("sram_addr", sram_addr, v.addr);
            if (v.exp_we) checkOutput("sram_wdata", sram_wdata, v.wdata);
        end
        tick();
        checkBit("done_re", sram_re, 1'b0);
        checkBit("done_we", sram_we, 1'b0);
        checkBit("done_stall", v.fetch ? if_stall : mem_stall, 1'b0);
        if_req = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        tick();
    endtask

    initial begin
        int c;
        rst = 1'b0;
        if_req = 1'b0; if_addr = '0; mem_rd = 1'b0; mem_wr = 1'b0;
        mem_addr = '0; mem_wdata = '0; sram_rdata = '0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         32'hE3A0_1005, 1'b0, 32'hE3A0_1005};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0,         32'h1234_5678, 1'b0, 32'h1234_5678};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'h0000_0055, 32'h9999_9999, 1'b1, 32'h1234_5678};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_0408, 32'hCAFE_F00D, 32'h0BAD_0BAD, 1'b1, 32'h1234_5678};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF};

        #12;
        checkBit("rst_sram_re", sram_re, 1'b0);
        checkBit("rst_sram_we", sram_we, 1'b0);
        checkBit("rst_if_ready", if_ready, 1'b0);
        checkBit("rst_mem_ready", mem_ready, 1'b0);
        checkOutput("rst_sram_addr", sram_addr, 32'h0);
        checkOutput("rst_sram_wdata", sram_wdata, 32'h0);
        checkOutput("rst_if_rdata", if_rdata, 32'h0);
        checkOutput("rst_mem_rdata", mem_rdata, 32'h0);
        @(negedge clk);
        #1 rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        $display("[TB] simultaneous fetch and data read");
        c = cyc;
        if_req = 1'b1; if_addr = 32'h300; mem_rd = 1'b1; mem_addr = 32'h500;
        sram_rdata = 32'h1111_2222;
        expect_ready(1'b0, 32'h1111_2222, c + 4);
        expect_ready(1'b1, 32'h3333_4444, c + 9);
        tick();
        checkOutput("simul_first_addr", sram_addr, 32'h500);
        tick(); tick(); tick();
        checkBit("simul_if_stall", if_stall, 1'b1);
        mem_rd = 1'b0;
        sram_rdata = 32'h3333_4444;
        tick(); tick();
        checkOutput("simul_second_addr", sram_addr, 32'h300);
        checkBit("simul_second_re", sram_re, 1'b1);
        tick(); tick(); tick();
        if_req = 1'b0;
        tick();

        $display("[TB] starvation with both ports held");
        c = cyc;
        if_req = 1'b1; if_addr = 32'h600; mem_rd = 1'b1; mem_addr = 32'h700;
        sram_rdata = 32'h5A5A_5A5A;
        expect_ready(1'b0, 32'h5A5A_5A5A, c + 4);
        expect_ready(1'b0, 32'h5A5A_5A5A, c + 9);
        expect_ready(1'b1, 32'h5A5A_5A5A, c + 14);
        expect_ready(1'b0, 32'h5A5A_5A5A, c + 19);
        expect_ready(1'b0, 32'h5A5A_5A5A, c + 24);
        expect_ready(1'b1, 32'h5A5A_5A5A, c + 29);
        for (int i = 0; i < 29; i++) tick();
        if_req = 1'b0; mem_rd = 1'b0;
        tick();

        $display("[TB] request dropped during access");
        c = cyc;
        mem_rd = 1'b1; mem_addr = 32'h800; sram_rdata = 32'h7777_8888;
        expect_ready(1'b0, 32'h7777_8888, c + 4);
        tick();
        mem_rd = 1'b0; mem_addr = 32'h900;
        tick();
        checkOutput("drop_addr_held", sram_addr, 32'h800);
        checkBit("drop_re_held", sram_re, 1'b1);
        tick(); tick(); tick();

        $display("[TB] reset during access");
        mem_rd = 1'b1; mem_addr = 32'hA00; sram_rdata = 32'h1357_2468;
        tick(); tick();
        checkBit("pre_abort_re", sram_re, 1'b1);
        rst = 1'b0;
        #1;
        checkBit("abort_re", sram_re, 1'b0);
        checkBit("abort_ready", mem_ready, 1'b0);
        checkOutput("abort_mem_rdata", mem_rdata, 32'h0);
        checkOutput("abort_addr", sram_addr, 32'h0);
        tick(); tick();
        checkBit("abort_no_ready", mem_ready, 1'b0);
        rst = 1'b1;
        expect_ready(1'b0, 32'h1357_2468, cyc + 4);
        for (int i = 1; i <= WAIT; i++) begin
            tick();
            checkBit("post_rst_re", sram_re, 1'b1);
            checkOutput("post_rst_addr", sram_addr, 32'hA00);
        end
        tick();
        mem_rd = 1'b0;
        tick(); tick();

        checkOutput("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
